// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle MIPS control FSM.
//   state_t    controller states; EXC is split into EXC (EPC save),
//              EXC_RD (vector fetch) and EXC_PC (PC load from MDR)
//   op_t       instruction classes produced by ctrl_opdecode
//   OPC_*/FN_* opcode and R-type funct constants
//   ALU_*, SRCA_*, SRCB_*, IORD_*, EXC_*, DST_*, M2R_*, PCS_*  datapath encodings
//   VEC_*_DEF  default exception vector byte addresses
package ctrl_pkg;
   typedef enum logic [3:0] {
      S_RESET, S_FETCH, S_IR_WR, S_DECODE, S_EXEC, S_WB, S_ADDR, S_MEM_RD,
      S_LWB, S_MEM_WR, S_BRANCH, S_JUMP, S_EXC, S_EXC_RD, S_EXC_PC
   } state_t;
   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J
   } op_t;
   localparam logic [5:0] OPC_R = 6'b000000, OPC_ADDI = 6'b001000, OPC_ADDIU = 6'b001001;
   localparam logic [5:0] OPC_LW = 6'b100011, OPC_SW = 6'b101011;
   localparam logic [5:0] OPC_BEQ = 6'b000100, OPC_BNE = 6'b000101, OPC_J = 6'b000010;
   localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
   localparam logic [2:0] ALU_NOP = 3'b000, ALU_ADD = 3'b001, ALU_SUB = 3'b010, ALU_AND = 3'b011;
   localparam logic [1:0] SRCA_PC = 2'b00, SRCA_A = 2'b01;
   localparam logic [1:0] SRCB_B = 2'b00, SRCB_4 = 2'b01, SRCB_IMM = 2'b10, SRCB_BR = 2'b11;
   localparam logic [1:0] IORD_PC = 2'b00, IORD_ALU = 2'b01, IORD_VEC = 2'b10;
   localparam logic [1:0] EXC_INV = 2'b00, EXC_OVF = 2'b01;
   localparam logic [1:0] DST_RT = 2'b00, DST_RD = 2'b01;
   localparam logic [2:0] M2R_ALU = 3'b000, M2R_MDR = 3'b001;
   localparam logic [2:0] PCS_ALUOUT = 3'b010, PCS_JUMP = 3'b011, PCS_MDR = 3'b100;
   localparam logic [7:0] VEC_INV_DEF = 8'd253, VEC_OVF_DEF = 8'd254;
   function automatic logic is_r(input op_t op);
      return op inside {OP_ADD, OP_SUB, OP_AND};
   endfunction
   // ADDIU and AND never trap; only the signed arithmetic ops do
   function automatic logic ovf_trap(input op_t op);
      return op inside {OP_ADD, OP_SUB, OP_ADDI};
   endfunction
   function automatic logic [2:0] alu_of(input op_t op);
      return op == OP_SUB ? ALU_SUB : op == OP_AND ? ALU_AND : ALU_ADD;
   endfunction
endpackage

// File: rtl/ctrl_opdecode.sv
// ctrl_opdecode: combinational opcode/funct classifier.
//   opcode  in  6  IR[31:26]
//   funct   in  6  IR[5:0]
//   op      out    instruction class
//   legal   out 1  low for any opcode/funct the controller does not implement
module ctrl_opdecode
   import ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output op_t        op,
   output logic       legal
);
   always_comb begin
      op = OP_ADD;
      legal = 1'b1;
      case (opcode)
         OPC_R:
            case (funct)
               FN_ADD:  op = OP_ADD;
               FN_SUB:  op = OP_SUB;
               FN_AND:  op = OP_AND;
               default: legal = 1'b0;
            endcase
         OPC_ADDI:  op = OP_ADDI;
         OPC_ADDIU: op = OP_ADDIU;
         OPC_LW:    op = OP_LW;
         OPC_SW:    op = OP_SW;
         OPC_BEQ:   op = OP_BEQ;
         OPC_BNE:   op = OP_BNE;
         OPC_J:     op = OP_J;
         default:   legal = 1'b0;
      endcase
   end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS control FSM with memory wait states and precise exceptions.
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   OPCODE, OFFSET         IR[31:26], IR[15:0] (FUNCT = OFFSET[5:0])
//   Overflow, ZR           ALU signed overflow and zero flags
//   PCwrite..ALUOutWrite   datapath write enables
//   ALUOp, ALUSrcA/B, IorD, Exception, RegDst, MemToReg, PCSource  datapath selects
//   rst_out                datapath register clear, high only in RESET
module mc_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 2,
   parameter logic [7:0]  VEC_INV  = VEC_INV_DEF,
   parameter logic [7:0]  VEC_OVF  = VEC_OVF_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  OPCODE,
   input  logic [15:0] OFFSET,
   input  logic        Overflow,
   input  logic        ZR,
   output logic        PCwrite,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        BRWrite,
   output logic        ABWrite,
   output logic        EPCWrite,
   output logic        MDRWrite,
   output logic        ALUOutWrite,
   output logic [2:0]  ALUOp,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  IorD,
   output logic [1:0]  Exception,
   output logic [1:0]  RegDst,
   output logic [2:0]  MemToReg,
   output logic [2:0]  PCSource,
   output logic        rst_out
);
   localparam int CW = (MEM_WAIT == 0) ? 1 : $clog2(MEM_WAIT + 1);
   localparam logic [CW-1:0] LAST = CW'(MEM_WAIT);
   state_t        state;
   logic [CW-1:0] cnt;
   op_t           op, op_q;
   logic          legal, last;
   logic [1:0]    exc_sel;
   // the vector addresses live in the datapath's vector mux; only the select leaves this block
   logic          unused_bits;
   assign unused_bits = ^{OFFSET[15:6], VEC_INV, VEC_OVF};
   assign last = (cnt == LAST);
   ctrl_opdecode u_dec (.opcode(OPCODE), .funct(OFFSET[5:0]), .op(op), .legal(legal));
   // cnt defaults to zero each cycle so it clears on every state change and only
   // advances while a wait state is still short of its last cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_RESET;
         cnt     <= '0;
         op_q    <= OP_ADD;
         exc_sel <= EXC_INV;
      end else begin
         cnt <= '0;
         case (state)
            S_RESET:  state <= S_FETCH;
            S_FETCH:  if (last) state <= S_IR_WR; else cnt <= cnt + 1'b1;
            S_IR_WR:  state <= S_DECODE;
            S_DECODE: begin
               op_q    <= op;
               exc_sel <= EXC_INV;
               state   <= !legal ? S_EXC :
                          op inside {OP_LW, OP_SW}   ? S_ADDR :
                          op inside {OP_BEQ, OP_BNE} ? S_BRANCH :
                          op == OP_J                 ? S_JUMP : S_EXEC;
            end
            S_EXEC: begin
               if (Overflow && ovf_trap(op_q)) begin
                  state   <= S_EXC;
                  exc_sel <= EXC_OVF;
               end else state <= S_WB;
            end
            S_ADDR:   state <= (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (last) state <= S_LWB; else cnt <= cnt + 1'b1;
            S_EXC:    state <= S_EXC_RD;
            S_EXC_RD: if (last) state <= S_EXC_PC; else cnt <= cnt + 1'b1;
            default:  state <= S_FETCH;
         endcase
      end
   end
   always_comb begin
      PCwrite = 1'b0;
      MemWrite = 1'b0;
      IRWrite = 1'b0;
      BRWrite = 1'b0;
      ABWrite = 1'b0;
      EPCWrite = 1'b0;
      MDRWrite = 1'b0;
      ALUOutWrite = 1'b0;
      ALUOp = ALU_NOP;
      ALUSrcA = SRCA_PC;
      ALUSrcB = SRCB_B;
      IorD = IORD_PC;
      Exception = EXC_INV;
      RegDst = DST_RT;
      MemToReg = M2R_ALU;
      PCSource = 3'b000;
      rst_out = 1'b0;
      case (state)
         S_RESET:  rst_out = 1'b1;
         S_FETCH: begin
            ALUSrcB = SRCB_4;
            ALUOp = ALU_ADD;
            ALUOutWrite = 1'b1;
         end
         S_IR_WR: begin
            PCwrite = 1'b1;
            PCSource = PCS_ALUOUT;
            IRWrite = 1'b1;
         end
         S_DECODE: begin
            ABWrite = 1'b1;
            ALUOutWrite = 1'b1;
            ALUSrcB = SRCB_BR;
            ALUOp = ALU_ADD;
         end
         S_EXEC: begin
            ALUSrcA = SRCA_A;
            ALUSrcB = is_r(op_q) ? SRCB_B : SRCB_IMM;
            ALUOp = alu_of(op_q);
            ALUOutWrite = 1'b1;
         end
         S_WB: begin
            BRWrite = 1'b1;
            RegDst = is_r(op_q) ? DST_RD : DST_RT;
         end
         S_ADDR: begin
            ALUSrcA = SRCA_A;
            ALUSrcB = SRCB_IMM;
            ALUOp = ALU_ADD;
            ALUOutWrite = 1'b1;
         end
         S_MEM_RD: begin
            IorD = IORD_ALU;
            MDRWrite = last;
         end
         S_LWB: begin
            BRWrite = 1'b1;
            MemToReg = M2R_MDR;
         end
         S_MEM_WR: begin
            IorD = IORD_ALU;
            MemWrite = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA = SRCA_A;
            ALUOp = ALU_SUB;
            PCwrite = (op_q == OP_BEQ) ? ZR : !ZR;
            PCSource = PCS_ALUOUT;
         end
         S_JUMP: begin
            PCwrite = 1'b1;
            PCSource = PCS_JUMP;
         end
         S_EXC: begin
            EPCWrite = 1'b1;
            ALUSrcB = SRCB_4;
            ALUOp = ALU_SUB;
            Exception = exc_sel;
         end
         S_EXC_RD: begin
            IorD = IORD_VEC;
            MDRWrite = last;
            Exception = exc_sel;
         end
         S_EXC_PC: begin
            PCwrite = 1'b1;
            PCSource = PCS_MDR;
            Exception = exc_sel;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: two controllers (MEM_WAIT=2 and MEM_WAIT=0) each run one instruction
// repeatedly after a reset; a per-instruction cycle-table model predicts every output cycle.
module tb_mc_ctrl_fsm;
   typedef struct packed {
      logic       pcw, memw, irw, brw, abw, epcw, mdrw, aluow;
      logic [2:0] aluop;
      logic [1:0] srca, srcb, iord, exc, regdst;
      logic [2:0] m2r, pcsrc;
      logic       rsto;
   } ctl_t;
   localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_ADDI = 3, K_ADDIU = 4, K_LW = 5;
   localparam int K_SW = 6, K_BEQ = 7, K_BNE = 8, K_J = 9, K_ILL = 10;
   logic clk = 1'b0, reset = 1'b1;
   logic [5:0] OPCODE = '0;
   logic [15:0] OFFSET = '0;
   logic Overflow = 1'b0, ZR = 1'b0;
   wire [1:0] pcw, memw, irw, brw, abw, epcw, mdrw, aluow, rsto;
   wire [1:0][2:0] aluop, m2r, pcsrc;
   wire [1:0][1:0] srca, srcb, iord, excs, regdst;
   ctl_t q0[$], q2[$];
   int total = 0, bad = 0, cyc = 0, tid = 0;
   logic active = 1'b0;
   always #5 clk = ~clk;
   mc_ctrl_fsm #(.MEM_WAIT(2)) dut2 (
      .clk(clk), .reset(reset), .OPCODE(OPCODE), .OFFSET(OFFSET), .Overflow(Overflow), .ZR(ZR),
      .PCwrite(pcw[1]), .MemWrite(memw[1]), .IRWrite(irw[1]), .BRWrite(brw[1]), .ABWrite(abw[1]),
      .EPCWrite(epcw[1]), .MDRWrite(mdrw[1]), .ALUOutWrite(aluow[1]), .ALUOp(aluop[1]),
      .ALUSrcA(srca[1]), .ALUSrcB(srcb[1]), .IorD(iord[1]), .Exception(excs[1]),
      .RegDst(regdst[1]), .MemToReg(m2r[1]), .PCSource(pcsrc[1]), .rst_out(rsto[1]));
   mc_ctrl_fsm #(.MEM_WAIT(0)) dut0 (
      .clk(clk), .reset(reset), .OPCODE(OPCODE), .OFFSET(OFFSET), .Overflow(Overflow), .ZR(ZR),
      .PCwrite(pcw[0]), .MemWrite(memw[0]), .IRWrite(irw[0]), .BRWrite(brw[0]), .ABWrite(abw[0]),
      .EPCWrite(epcw[0]), .MDRWrite(mdrw[0]), .ALUOutWrite(aluow[0]), .ALUOp(aluop[0]),
      .ALUSrcA(srca[0]), .ALUSrcB(srcb[0]), .IorD(iord[0]), .Exception(excs[0]),
      .RegDst(regdst[0]), .MemToReg(m2r[0]), .PCSource(pcsrc[0]), .rst_out(rsto[0]));
   function automatic ctl_t obs(input int i);
      return {pcw[i], memw[i], irw[i], brw[i], abw[i], epcw[i], mdrw[i], aluow[i], aluop[i],
              srca[i], srcb[i], iord[i], excs[i], regdst[i], m2r[i], pcsrc[i], rsto[i]};
   endfunction
   function automatic ctl_t rst_b();
      ctl_t c = '0;
      c.rsto = 1'b1;
      return c;
   endfunction
   function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
      case (o)
         6'h00:   return f == 6'h20 ? K_ADD : f == 6'h22 ? K_SUB : f == 6'h24 ? K_AND : K_ILL;
         6'h08:   return K_ADDI;
         6'h09:   return K_ADDIU;
         6'h23:   return K_LW;
         6'h2b:   return K_SW;
         6'h04:   return K_BEQ;
         6'h05:   return K_BNE;
         6'h02:   return K_J;
         default: return K_ILL;
      endcase
   endfunction
   function automatic void push(input int i, input ctl_t c);
      if (i != 0) q2.push_back(c); else q0.push_back(c);
   endfunction
   function automatic void gen_exc(input int i, input logic [1:0] e);
      int w = (i != 0) ? 2 : 0;
      ctl_t c;
      c = '0; c.epcw = 1; c.srcb = 2'b01; c.aluop = 3'b010; c.exc = e; push(i, c);
      for (int j = 0; j <= w; j++) begin
         c = '0; c.iord = 2'b10; c.exc = e; c.mdrw = (j == w); push(i, c);
      end
      c = '0; c.pcw = 1; c.pcsrc = 3'b100; c.exc = e; push(i, c);
   endfunction
   function automatic void gen(input int i, input int k, input logic ovf, input logic zr);
      int w = (i != 0) ? 2 : 0;
      ctl_t c;
      for (int j = 0; j <= w; j++) begin
         c = '0; c.srcb = 2'b01; c.aluop = 3'b001; c.aluow = 1; push(i, c);
      end
      c = '0; c.pcw = 1; c.pcsrc = 3'b010; c.irw = 1; push(i, c);
      c = '0; c.abw = 1; c.aluow = 1; c.srcb = 2'b11; c.aluop = 3'b001; push(i, c);
      if (k <= K_ADDIU) begin
         c = '0; c.srca = 2'b01; c.srcb = (k <= K_AND) ? 2'b00 : 2'b10; c.aluow = 1;
         c.aluop = (k == K_SUB) ? 3'b010 : (k == K_AND) ? 3'b011 : 3'b001;
         push(i, c);
         if (ovf && (k == K_ADD || k == K_SUB || k == K_ADDI)) gen_exc(i, 2'b01);
         else begin
            c = '0; c.brw = 1; c.regdst = (k <= K_AND) ? 2'b01 : 2'b00; push(i, c);
         end
      end else if (k == K_LW || k == K_SW) begin
         c = '0; c.srca = 2'b01; c.srcb = 2'b10; c.aluop = 3'b001; c.aluow = 1; push(i, c);
         if (k == K_SW) begin
            c = '0; c.iord = 2'b01; c.memw = 1; push(i, c);
         end else begin
            for (int j = 0; j <= w; j++) begin
               c = '0; c.iord = 2'b01; c.mdrw = (j == w); push(i, c);
            end
            c = '0; c.brw = 1; c.m2r = 3'b001; push(i, c);
         end
      end else if (k == K_BEQ || k == K_BNE) begin
         c = '0; c.srca = 2'b01; c.aluop = 3'b010; c.pcsrc = 3'b010;
         c.pcw = (k == K_BEQ) ? zr : !zr;
         push(i, c);
      end else if (k == K_J) begin
         c = '0; c.pcw = 1; c.pcsrc = 3'b011; push(i, c);
      end else gen_exc(i, 2'b00);
   endfunction
   task automatic chk(input string nm, input ctl_t got, input ctl_t exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s test=%0d cyc=%0d got=%h exp=%h", nm, tid, cyc, got, exp);
      end
   endtask
   task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s test=%0d cyc=%0d got=%h exp=%h", nm, tid, cyc, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (active) begin
         if (q2.size() > 0) chk("seq_mw2", obs(1), q2.pop_front());
         if (q0.size() > 0) chk("seq_mw0", obs(0), q0.pop_front());
         if (cyc == 1) lit("release_fetch", {iord[1], aluop[1], iord[0], aluop[0]}, 10'b00_001_00_001);
         if (tid == 1 && cyc == 4) lit("add_pcwrite_c4", 32'(pcw[1]), 1);
         if (tid == 1 && cyc == 7) lit("add_wb_c7", {brw[1], regdst[1]}, 3'b101);
         if (tid == 4 && cyc == 7) lit("addi_ovf_epc_c7", {epcw[1], brw[1], excs[1]}, 4'b1001);
         if (tid == 4 && cyc == 11) lit("addi_ovf_pc_c11", {pcw[1], pcsrc[1], excs[1]}, 6'b1_100_01);
         if (tid == 14 && cyc >= 7 && cyc <= 9) lit("ill_vec_read", {iord[1], excs[1]}, 4'b1000);
         if (tid == 14 && cyc == 11) lit("ill_refetch", {iord[1], aluop[1], epcw[1]}, 6'b00_001_0);
         if (tid == 16 && cyc == 5) lit("lw_mw0_mdr_c5", {mdrw[0], iord[0]}, 3'b101);
         if (tid == 16 && cyc == 6) lit("lw_mw0_wb_c6", {brw[0], m2r[0]}, 4'b1001);
         cyc++;
      end else cyc = 0;
   end
   task automatic run(input int id, input logic [5:0] opc, input logic [5:0] fn,
                      input logic ovf, input logic zr, input int n);
      int k = kind_of(opc, fn);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_mw2", obs(1), rst_b());
      chk("async_rst_mw0", obs(0), rst_b());
      OPCODE = opc;
      OFFSET = {10'h2a5, fn};
      Overflow = ovf;
      ZR = zr;
      tid = id;
      repeat (3) begin
         @(negedge clk);
         chk("held_rst_mw2", obs(1), rst_b());
         chk("held_rst_mw0", obs(0), rst_b());
      end
      q0.delete();
      q2.delete();
      push(1, rst_b());
      push(0, rst_b());
      while (q2.size() < n) gen(1, k, ovf, zr);
      while (q0.size() < n) gen(0, k, ovf, zr);
      q2 = q2[0:n-1];
      q0 = q0[0:n-1];
      @(posedge clk);
      #2;
      reset = 1'b0;
      active = 1'b1;
      for (int j = 0; j < n + 4 && (q0.size() > 0 || q2.size() > 0); j++) @(posedge clk);
      if (q0.size() > 0 || q2.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain test=%0d left=%0d/%0d", id, q2.size(), q0.size());
      end
      #2;
      active = 1'b0;
   endtask
   initial begin
      run(1,  6'h00, 6'h20, 1'b0, 1'b0, 16);
      run(2,  6'h00, 6'h22, 1'b0, 1'b0, 16);
      run(3,  6'h00, 6'h24, 1'b1, 1'b0, 16);
      run(4,  6'h08, 6'h00, 1'b1, 1'b0, 14);
      run(5,  6'h09, 6'h3f, 1'b1, 1'b0, 16);
      run(6,  6'h00, 6'h22, 1'b1, 1'b0, 14);
      run(7,  6'h23, 6'h00, 1'b0, 1'b0, 9);
      run(8,  6'h2b, 6'h00, 1'b0, 1'b0, 14);
      run(9,  6'h04, 6'h00, 1'b0, 1'b1, 12);
      run(10, 6'h04, 6'h00, 1'b0, 1'b0, 12);
      run(11, 6'h05, 6'h00, 1'b0, 1'b1, 12);
      run(12, 6'h05, 6'h00, 1'b0, 1'b0, 12);
      run(13, 6'h02, 6'h00, 1'b0, 1'b0, 12);
      run(14, 6'h3f, 6'h00, 1'b0, 1'b0, 14);
      run(15, 6'h00, 6'h21, 1'b0, 1'b0, 12);
      run(16, 6'h23, 6'h00, 1'b0, 1'b0, 20);
      run(17, 6'h00, 6'h20, 1'b1, 1'b0, 16);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog test=%0d", tid);
      $fatal(1, "watchdog expired");
   end
endmodule
